// File: rtl/display_scan_ctrl_pkg.sv
// Shared definitions for the multiplexed 4-digit display scanner:
// FSM state encoding, one-hot digit codes and rotation/anode helpers.
package display_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } scan_state_e;

    localparam logic [3:0] DIG_UNI = 4'b0001;
    localparam logic [3:0] DIG_DEC = 4'b0010;
    localparam logic [3:0] DIG_CEN = 4'b0100;
    localparam logic [3:0] DIG_MIL = 4'b1000;

    // Any non-one-hot code (e.g. an upset) falls back to unidades.
    function automatic logic [3:0] next_digit(input logic [3:0] cur);
        logic [3:0] nxt;
        case (cur)
            DIG_UNI: nxt = DIG_DEC;
            DIG_DEC: nxt = DIG_CEN;
            DIG_CEN: nxt = DIG_MIL;
            DIG_MIL: nxt = DIG_UNI;
            default: nxt = DIG_UNI;
        endcase
        return nxt;
    endfunction

    function automatic logic [3:0] anode_drive(input logic [3:0] dig,
                                               input logic [3:0] mask);
        return ~(dig & ~mask);
    endfunction

endpackage

// File: rtl/display_scan_ctrl_timer.sv
// scan_timer: clearable up-counter with a runtime-selectable terminal count.
module scan_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic [WIDTH-1:0] term,
    output logic             tc
);

    logic [WIDTH-1:0] count_r;

    // Counter register: clear has priority over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {WIDTH{1'b0}};
        end else if (clr) begin
            count_r <= {WIDTH{1'b0}};
        end else if (inc) begin
            count_r <= count_r + WIDTH'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign tc = (count_r == term);

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit display scan controller: rotates a one-hot digit select and
// drives active-low anodes with an anode-off gap between digits.
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int DIGIT_CYCLES = 27000,
    parameter int GAP_CYCLES   = 270
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] blank_mask,
    output logic [3:0] sel,
    output logic [3:0] an_n,
    output logic       digit_tick
);

    localparam int MAX_CYCLES = (DIGIT_CYCLES > GAP_CYCLES) ? DIGIT_CYCLES : GAP_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam bit HAS_GAP    = (GAP_CYCLES > 0);
    localparam logic [CW-1:0] SHOW_TERM = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] GAP_TERM  = CW'(HAS_GAP ? (GAP_CYCLES - 1) : 0);

    scan_state_e   state_r;
    scan_state_e   state_nxt_s;
    logic [3:0]    sel_r;
    logic [3:0]    sel_nxt_s;
    logic          tick_r;
    logic          tick_nxt_s;
    logic          tmr_clr_s;
    logic          tmr_inc_s;
    logic          tmr_tc_s;
    logic [CW-1:0] tmr_term_s;
    logic [3:0]    an_n_s;

    assign tmr_term_s = (state_r == GAP) ? GAP_TERM : SHOW_TERM;

    scan_timer #(
        .WIDTH (CW)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tmr_clr_s),
        .inc   (tmr_inc_s),
        .term  (tmr_term_s),
        .tc    (tmr_tc_s)
    );

    // State, digit select and tick registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            sel_r   <= DIG_UNI;
            tick_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            sel_r   <= sel_nxt_s;
            tick_r  <= tick_nxt_s;
        end
    end

    // Next-state, rotation and timer control; disable wins over everything.
    always_comb begin
        state_nxt_s = state_r;
        sel_nxt_s   = sel_r;
        tick_nxt_s  = 1'b0;
        tmr_clr_s   = 1'b0;
        tmr_inc_s   = 1'b0;
        if (!en) begin
            state_nxt_s = IDLE;
            tmr_clr_s   = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    state_nxt_s = SHOW;
                    tick_nxt_s  = 1'b1;
                    tmr_clr_s   = 1'b1;
                end
                SHOW: begin
                    if (tmr_tc_s) begin
                        tmr_clr_s = 1'b1;
                        if (HAS_GAP) begin
                            state_nxt_s = GAP;
                        end else begin
                            sel_nxt_s  = next_digit(sel_r);
                            tick_nxt_s = 1'b1;
                        end
                    end else begin
                        tmr_inc_s = 1'b1;
                    end
                end
                GAP: begin
                    if (tmr_tc_s) begin
                        tmr_clr_s   = 1'b1;
                        state_nxt_s = SHOW;
                        sel_nxt_s   = next_digit(sel_r);
                        tick_nxt_s  = 1'b1;
                    end else begin
                        tmr_inc_s = 1'b1;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    tmr_clr_s   = 1'b1;
                end
            endcase
        end
    end

    // Anode drive: only en and blank_mask act combinationally on the held state.
    always_comb begin
        an_n_s = 4'b1111;
        if (en && (state_r == SHOW)) begin
            an_n_s = anode_drive(sel_r, blank_mask);
        end else begin
            an_n_s = 4'b1111;
        end
    end

    assign an_n       = an_n_s;
    assign sel        = sel_r;
    assign digit_tick = tick_r;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized bench for display_scan_ctrl with a slot-arithmetic reference
// model; instance a has a gap between digits, instance b has none.
module tb_display_scan_ctrl;

    localparam int D = 4;
    localparam int G = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] blank_mask;
    logic [3:0] sel_a, an_a, sel_b, an_b;
    logic       tick_a, tick_b;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    // Model: per instance, whether a run is active, cycles since run start,
    // the digit the run started on, and the digit held while idle.
    bit act  [2] = '{1'b0, 1'b0};
    int t    [2] = '{0, 0};
    int base [2] = '{0, 0};
    int held [2] = '{0, 0};

    always #5 clk = ~clk;

    display_scan_ctrl #(.DIGIT_CYCLES(D), .GAP_CYCLES(G)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .blank_mask(blank_mask),
        .sel(sel_a), .an_n(an_a), .digit_tick(tick_a)
    );

    display_scan_ctrl #(.DIGIT_CYCLES(D), .GAP_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .blank_mask(blank_mask),
        .sel(sel_b), .an_n(an_b), .digit_tick(tick_b)
    );

    function automatic int slot_len(input int k);
        return (k == 0) ? (D + G) : D;
    endfunction

    function automatic int cur_digit(input int k);
        return act[k] ? ((base[k] + t[k] / slot_len(k)) % 4) : held[k];
    endfunction

    function automatic void model_out(input int k, output logic [3:0] s,
                                      output logic [3:0] a, output logic tk);
        int ph;
        ph = act[k] ? (t[k] % slot_len(k)) : -1;
        s  = 4'b0001 << cur_digit(k);
        tk = act[k] && (ph == 0);
        a  = (act[k] && (ph < D) && en) ? ~(s & ~blank_mask) : 4'b1111;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                act[k]  <= 1'b0;
                t[k]    <= 0;
                base[k] <= 0;
                held[k] <= 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (!en) begin
                    if (act[k]) held[k] <= cur_digit(k);
                    act[k] <= 1'b0;
                end else if (!act[k]) begin
                    act[k]  <= 1'b1;
                    t[k]    <= 0;
                    base[k] <= held[k];
                end else begin
                    t[k] <= t[k] + 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [3:0] es, ea;
        logic       et;
        if (chk_on) begin
            model_out(0, es, ea, et);
            check("sel_a", sel_a, es);
            check("an_a", an_a, ea);
            check("tick_a", {3'b000, tick_a}, {3'b000, et});
            model_out(1, es, ea, et);
            check("sel_b", sel_b, es);
            check("an_b", an_b, ea);
            check("tick_b", {3'b000, tick_b}, {3'b000, et});
            check("onehot_a", {3'b000, $onehot(sel_a)}, 4'b0001);
            check("onehot_b", {3'b000, $onehot(sel_b)}, 4'b0001);
            check("one_an_a", {3'b000, ($countones(~an_a) <= 1)}, 4'b0001);
            check("one_an_b", {3'b000, ($countones(~an_b) <= 1)}, 4'b0001);
        end
    end

    initial begin
        int  n;
        bit  found;
        bit  rst_pend;
        rst_n      = 1'b0;
        en         = 1'b0;
        blank_mask = 4'b0000;
        chk_on     = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("rst_sel", sel_a, 4'b0001);
        check("rst_an", an_a, 4'b1111);
        check("rst_tick", {3'b000, tick_a}, 4'b0000);

        // Release with en high: first SHOW on unidades.
        en    = 1'b1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("first_sel", sel_a, 4'b0001);
        check("first_an", an_a, 4'b1110);
        check("first_tick", {3'b000, tick_a}, 4'b0001);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("slot1_sel", sel_a, 4'b0010);
        check("slot1_an", an_a, 4'b1101);
        check("slot1_tick", {3'b000, tick_a}, 4'b0001);
        check("nogap_sel_t6", sel_b, 4'b0010);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("gap_an", an_a, 4'b1111);
        check("gap_sel", sel_a, 4'b0010);
        check("nogap_sel_t10", sel_b, 4'b0100);
        check("nogap_an_t10", an_b, 4'b1011);

        // Blank decenas and millares for two full scans.
        @(posedge clk); #2;
        blank_mask = 4'b1010;
        repeat (48) @(posedge clk);

        // Drop en while centenas is showing, then resume.
        found = 1'b0;
        n = 0;
        while (!found && n < 60) begin
            @(negedge clk);
            n++;
            if (sel_a == 4'b0100 && an_a != 4'b1111) found = 1'b1;
        end
        check("find_cen_show", {3'b000, found}, 4'b0001);
        @(posedge clk); #2;
        en = 1'b0;
        #1;
        check("drop_an", an_a, 4'b1111);
        check("drop_sel", sel_a, 4'b0100);
        @(posedge clk); #2;
        en         = 1'b1;
        blank_mask = 4'b0000;
        @(posedge clk); #1;
        check("resume_sel", sel_a, 4'b0100);
        check("resume_tick", {3'b000, tick_a}, 4'b0001);
        check("resume_an", an_a, 4'b1011);

        // Reset during the millares gap.
        found = 1'b0;
        n = 0;
        while (!found && n < 60) begin
            @(negedge clk);
            n++;
            if (sel_a == 4'b1000 && an_a == 4'b1111) found = 1'b1;
        end
        check("find_mil_gap", {3'b000, found}, 4'b0001);
        #1;
        rst_n = 1'b0;
        #1;
        check("midgap_rst_sel", sel_a, 4'b0001);
        check("midgap_rst_an", an_a, 4'b1111);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("restart_sel", sel_a, 4'b0001);
        check("restart_tick", {3'b000, tick_a}, 4'b0001);

        // Random enable, mask and reset activity.
        rst_pend = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            int r;
            @(posedge clk); #2;
            r = $urandom_range(0, 99);
            if (rst_pend) begin
                rst_n    = 1'b1;
                rst_pend = 1'b0;
            end else if (r == 10) begin
                rst_n    = 1'b0;
                rst_pend = 1'b1;
            end
            if (r < 4) en = ~en;
            else if (r < 10) blank_mask = 4'($urandom_range(0, 15));
        end
        rst_n = 1'b1;
        en    = 1'b1;
        repeat (30) @(posedge clk);
        @(negedge clk);
        #1;
        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
